pointing_device_arbiter: RTL and testbench
==========================================

POINTING_DEVICE_ARBITER -- requirements
Module: pointing_device_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 8, byte depth of each per-port input FIFO (power of two, >= 4).
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 overclock  input  1  selects byte pacing period (REQ-012).
REQ-005 in0  bytestream.sink  write 1 / data 8  pointing-device byte stream, port 0.
REQ-006 in1  bytestream.sink  write 1 / data 8  pointing-device byte stream, port 1.
REQ-007 serial_out  bytestream.source  write 1 / data 8  merged byte stream to the UART receive path.
REQ-008 active_port  output  1  port owning the packet currently in transfer; holds last value when idle.
REQ-009 overflow  output  2  sticky per-port flag; bit n set when a byte to port n was dropped.

Function
REQ-010 Each port SHALL buffer incoming bytes in its own FIFO; a write and a read on the same FIFO in one cycle SHALL both take effect, count unchanged.
REQ-011 Packet framing, by FIFO head byte: 8'hCA = 1-byte packet; bits[7:6]=2'b11 otherwise = 3-byte packet (header); bits[7:6]!=2'b11 = stray byte.
REQ-012 Pacing: successive serial_out.write pulses SHALL be at least kTicks cycles apart; kTicks = 250000 when overclock=0, 200000 when overclock=1, sampled when the gap counter is loaded.
REQ-013 Gap counter: loads kTicks-1 on each output byte, decrements to 0 and holds; it is 0 after reset.
REQ-014 State machine: IDLE, SEND, GAP.
REQ-015 IDLE: a port is eligible when its head is a header and its FIFO count >= packet length; grant the eligible port, round-robin -> SEND.
REQ-016 Round-robin: with both ports eligible, the port not granted last SHALL win; the pointer is 0 after reset.
REQ-017 IDLE: a stray byte at a FIFO head SHALL be popped, one per cycle per port, without output (resync); this is never done while that port is granted.
REQ-018 SEND (gap counter 0): pop one byte from the granted FIFO; drive serial_out.data with it and pulse serial_out.write for exactly 1 cycle -> GAP.
REQ-019 GAP: wait for gap counter 0; return to SEND while granted-packet bytes remain, else IDLE.
REQ-020 A packet SHALL never be interleaved with bytes of the other port.
REQ-021 Latency: with both FIFOs empty and gap counter 0, serial_out.write SHALL assert 2 cycles after the clock edge that writes a packet's last byte.
REQ-022 Full FIFO: an incoming byte SHALL be dropped and the port's overflow bit set; a FIFO that is full but is popped in the same cycle SHALL accept the byte.
REQ-023 A header whose continuation bytes were dropped is forwarded as received; the arbiter SHALL NOT repair packets.
REQ-024 Simultaneous writes to both ports SHALL both be accepted.

Reset
REQ-025 On reset: both FIFOs flushed; state IDLE; gap counter 0; round-robin pointer 0; active_port 0; overflow 2'b00; serial_out.write 0; serial_out.data 8'h00.
REQ-026 Reset during SEND or GAP SHALL abandon the packet; no further byte of it is emitted.

Verification
REQ-027 Port 0 writes CA: serial_out emits CA 2 cycles later; write pulse is 1 cycle wide; active_port=0.
REQ-028 Port 0 writes C0 05 80 with overclock=0: bytes emitted in order, exactly 250000 cycles apart.
REQ-029 Both ports complete a packet on the same cycle (P0: C0 01 82; P1: D0 02 83) after reset: P0 packet fully first, then P1; no interleave.
REQ-030 Port 1 writes 85 then CA: 85 discarded silently; CA emitted; overflow stays 00.
REQ-031 Port 0 receives 9 bytes with no drain (output stalled in GAP by a prior packet): 9th byte dropped; overflow=2'b01 until reset.
REQ-032 Reset asserted 10 cycles after the first byte of a 3-byte packet: no remaining bytes emitted; all outputs at reset values; next CA on port 1 emitted 2 cycles after its write.

Source files
------------

// File: rtl/pointing_device_arbiter.sv
// pointing_device_arbiter
//   Merges two pointing-device byte streams into one paced serial byte stream.
//   Each input port has its own FIFO. Whole packets (1-byte 8'hCA or 3-byte
//   packets whose header has bits[7:6]=2'b11) are forwarded without
//   interleaving. Ports are arbitrated round-robin, and output bytes are spaced
//   at least kTicks cycles apart. Stray bytes at an idle FIFO head are
//   discarded.
//
// Ports
//   clk              : single clock, rising edge
//   reset            : synchronous, active-high
//   overclock        : selects TICKS_OVERCLOCK (1) or TICKS_NORMAL (0) as the byte gap
//   in0_write/data   : byte stream sink, port 0
//   in1_write/data   : byte stream sink, port 1
//   serial_out_write : 1-cycle strobe for each output byte
//   serial_out_data  : output byte (holds its last value between strobes)
//   active_port      : port owning the current or most recent packet
//   overflow         : sticky per-port flag, set when an incoming byte was dropped
module pointing_device_arbiter #(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned TICKS_NORMAL    = 250000,
  parameter int unsigned TICKS_OVERCLOCK = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       overclock,
  input  logic       in0_write,
  input  logic [7:0] in0_data,
  input  logic       in1_write,
  input  logic [7:0] in1_data,
  output logic       serial_out_write,
  output logic [7:0] serial_out_data,
  output logic       active_port,
  output logic [1:0] overflow
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned TMAX = (TICKS_NORMAL > TICKS_OVERCLOCK) ? TICKS_NORMAL : TICKS_OVERCLOCK;
  localparam int unsigned GW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] LOAD_N = GW'(TICKS_NORMAL - 1);
  localparam logic [GW-1:0] LOAD_O = GW'(TICKS_OVERCLOCK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [7:0]    mem_q [0:1][0:FIFO_DEPTH-1];
  logic [AW-1:0] rd_q  [0:1];
  logic [AW-1:0] wr_q  [0:1];
  logic [CW-1:0] cnt_q [0:1];

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          rr_q, rr_d;
  logic          grant_q, grant_d;
  logic [1:0]    rem_q, rem_d;
  logic [1:0]    overflow_q;
  logic          out_wr_q;
  logic [7:0]    out_data_q;

  logic [1:0]    wr_en, acc, pop, elig, stray;
  logic [7:0]    wr_data [0:1];
  logic [7:0]    head    [0:1];
  logic [1:0]    need    [0:1];
  logic          emit;
  logic          pick;

  // Per-port FIFO head classification
  always_comb begin
    wr_en      = {in1_write, in0_write};
    wr_data[0] = in0_data;
    wr_data[1] = in1_data;
    for (int unsigned p = 0; p < 2; p++) begin
      head[p]  = mem_q[p][rd_q[p]];
      need[p]  = (head[p] == 8'hCA) ? 2'd1 : 2'd3;
      elig[p]  = (cnt_q[p] != '0) && (head[p][7:6] == 2'b11) && (cnt_q[p] >= CW'(need[p]));
      stray[p] = (cnt_q[p] != '0) && (head[p][7:6] != 2'b11);
      // A full FIFO still accepts a byte when it is popped in the same cycle
      acc[p]   = wr_en[p] && ((cnt_q[p] != FULL) || pop[p]);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    rem_d   = rem_q;
    pop     = '0;
    emit    = 1'b0;
    pick    = 1'b0;
    case (state_q)
      S_IDLE: begin
        pop = stray;
        if (elig != 2'b00) begin
          // rr_q names the port preferred on a tie; it then passes to the other port
          pick    = (elig == 2'b11) ? rr_q : elig[1];
          grant_d = pick;
          rr_d    = ~pick;
          rem_d   = need[pick];
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (gap_q == '0) begin
          pop[grant_q] = 1'b1;
          emit         = 1'b1;
          rem_d        = rem_q - 2'd1;
          state_d      = S_GAP;
        end
      end
      S_GAP: begin
        // Leave one cycle early so the next SEND sees a zero gap counter and the
        // strobe spacing is exactly kTicks cycles
        if (gap_q <= GW'(1)) begin
          state_d = (rem_q != 2'd0) ? S_SEND : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      gap_d = overclock ? LOAD_O : LOAD_N;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  // FIFO storage is not reset; flushing is done through the pointers
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (acc[p]) begin
        mem_q[p][wr_q[p]] <= wr_data[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned p = 0; p < 2; p++) begin
        rd_q[p]  <= '0;
        wr_q[p]  <= '0;
        cnt_q[p] <= '0;
      end
      state_q    <= S_IDLE;
      gap_q      <= '0;
      rr_q       <= 1'b0;
      grant_q    <= 1'b0;
      rem_q      <= 2'd0;
      overflow_q <= 2'b00;
      out_wr_q   <= 1'b0;
      out_data_q <= 8'h00;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (acc[p]) begin
          wr_q[p] <= wr_q[p] + AW'(1);
        end
        if (pop[p]) begin
          rd_q[p] <= rd_q[p] + AW'(1);
        end
        cnt_q[p] <= cnt_q[p] + CW'(acc[p]) - CW'(pop[p]);
        if (wr_en[p] && !acc[p]) begin
          overflow_q[p] <= 1'b1;
        end
      end
      state_q  <= state_d;
      gap_q    <= gap_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      rem_q    <= rem_d;
      out_wr_q <= emit;
      if (emit) begin
        out_data_q <= head[grant_q];
      end
    end
  end

  assign serial_out_write = out_wr_q;
  assign serial_out_data  = out_data_q;
  assign active_port      = grant_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_pointing_device_arbiter.sv
// tb_pointing_device_arbiter
//   Directed bench for pointing_device_arbiter with short pacing periods.
//   A monitor records every output strobe (data, cycle, active_port). The
//   directed sequence compares those records against hand-computed values.
module tb_pointing_device_arbiter;

  localparam int TN = 20;
  localparam int TO = 12;

  logic       clk = 1'b0;
  logic       reset, overclock;
  logic       in0_write, in1_write;
  logic [7:0] in0_data, in1_data;
  logic       serial_out_write;
  logic [7:0] serial_out_data;
  logic       active_port;
  logic [1:0] overflow;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int e;

  logic [7:0] q_data[$];
  int         q_cyc[$];
  logic       q_port[$];

  logic [7:0] exp_data [6];
  logic       exp_port [6];
  int         exp_diff [5];

  pointing_device_arbiter #(
    .FIFO_DEPTH(8),
    .TICKS_NORMAL(TN),
    .TICKS_OVERCLOCK(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .overclock(overclock),
    .in0_write(in0_write),
    .in0_data(in0_data),
    .in1_write(in1_write),
    .in1_data(in1_data),
    .serial_out_write(serial_out_write),
    .serial_out_data(serial_out_data),
    .active_port(active_port),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (serial_out_write === 1'b1) begin
      q_data.push_back(serial_out_data);
      q_cyc.push_back(cyc);
      q_port.push_back(active_port);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic step_in(input logic w0, input logic [7:0] d0, input logic w1, input logic [7:0] d1);
    in0_write = w0;
    in0_data  = d0;
    in1_write = w1;
    in1_data  = d1;
    tick();
    in0_write = 1'b0;
    in1_write = 1'b0;
  endtask

  task automatic wait_emits(input int n, input int limit, input string tag);
    for (int i = 0; i < limit && q_data.size() < n; i++) tick();
    chk(tag, 32'(q_data.size() >= n), 1);
  endtask

  task automatic clear_q();
    q_data.delete();
    q_cyc.delete();
    q_port.delete();
  endtask

  initial begin
    reset = 1'b1; overclock = 1'b0;
    in0_write = 1'b0; in1_write = 1'b0; in0_data = 8'h00; in1_data = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_write", serial_out_write, 0);
    chk("rst_data", serial_out_data, 8'h00);
    chk("rst_port", active_port, 0);
    chk("rst_overflow", overflow, 2'b00);

    // Single CA byte on port 0: two-cycle latency, one-cycle strobe
    clear_q();
    step_in(1'b1, 8'hCA, 1'b0, 8'h00);
    chk("ca_lat0", serial_out_write, 0);
    tick();
    chk("ca_lat1", serial_out_write, 0);
    tick();
    chk("ca_write", serial_out_write, 1);
    chk("ca_data", serial_out_data, 8'hCA);
    chk("ca_port", active_port, 0);
    tick();
    chk("ca_width", serial_out_write, 0);
    repeat (TN + 5) tick();

    // 3-byte packet, normal pacing
    clear_q();
    step_in(1'b1, 8'hC0, 1'b0, 8'h00);
    step_in(1'b1, 8'h05, 1'b0, 8'h00);
    step_in(1'b1, 8'h80, 1'b0, 8'h00);
    e = cyc;
    wait_emits(3, 3 * TN + 20, "pkt3_count");
    chk("pkt3_b0", q_data[0], 8'hC0);
    chk("pkt3_b1", q_data[1], 8'h05);
    chk("pkt3_b2", q_data[2], 8'h80);
    chk("pkt3_lat", q_cyc[0] - e, 2);
    chk("pkt3_gap1", q_cyc[1] - q_cyc[0], TN);
    chk("pkt3_gap2", q_cyc[2] - q_cyc[1], TN);
    repeat (TN + 5) tick();

    // Stray byte on port 1 is discarded, then CA passes
    clear_q();
    step_in(1'b0, 8'h00, 1'b1, 8'h85);
    step_in(1'b0, 8'h00, 1'b1, 8'hCA);
    e = cyc;
    wait_emits(1, 10, "stray_count");
    chk("stray_data", q_data[0], 8'hCA);
    chk("stray_port", q_port[0], 1);
    chk("stray_lat", q_cyc[0] - e, 2);
    repeat (TN + 5) tick();
    chk("stray_only_one", q_data.size(), 1);
    chk("stray_overflow", overflow, 2'b00);

    // Overflow: nine bytes arrive while the output is held in GAP
    clear_q();
    step_in(1'b1, 8'hCA, 1'b0, 8'h00);
    wait_emits(1, 10, "ovf_first");
    clear_q();
    for (int i = 0; i < 8; i++) step_in(1'b1, 8'hCA, 1'b0, 8'h00);
    chk("ovf_after8", overflow, 2'b00);
    step_in(1'b1, 8'hCA, 1'b0, 8'h00);
    chk("ovf_after9", overflow, 2'b01);
    wait_emits(8, 8 * (TN + 2) + 20, "ovf_drain");
    repeat (TN + 5) tick();
    chk("ovf_drain_count", q_data.size(), 8);
    chk("ovf_sticky", overflow, 2'b01);

    // Both ports complete a packet together after reset, overclocked pacing
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rr_overflow_cleared", overflow, 2'b00);
    overclock = 1'b1;
    clear_q();
    step_in(1'b1, 8'hC0, 1'b1, 8'hD0);
    step_in(1'b1, 8'h01, 1'b1, 8'h02);
    step_in(1'b1, 8'h82, 1'b1, 8'h83);
    e = cyc;
    wait_emits(6, 6 * TO + 40, "rr_count");
    exp_data = '{8'hC0, 8'h01, 8'h82, 8'hD0, 8'h02, 8'h83};
    exp_port = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_diff = '{TO, TO, TO + 1, TO, TO};
    chk("rr_lat", q_cyc[0] - e, 2);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_data%0d", i), q_data[i], exp_data[i]);
      chk($sformatf("rr_port%0d", i), q_port[i], exp_port[i]);
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_gap%0d", i), q_cyc[i+1] - q_cyc[i], exp_diff[i]);
    end

    // Reset in the middle of a 3-byte packet abandons it
    overclock = 1'b0;
    repeat (TN + 5) tick();
    clear_q();
    step_in(1'b1, 8'hC0, 1'b0, 8'h00);
    step_in(1'b1, 8'h01, 1'b0, 8'h00);
    step_in(1'b1, 8'h02, 1'b0, 8'h00);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_first_sent", q_data.size(), 1);
    chk("abort_write", serial_out_write, 0);
    chk("abort_data", serial_out_data, 8'h00);
    chk("abort_port", active_port, 0);
    chk("abort_overflow", overflow, 2'b00);
    repeat (3 * TN) tick();
    chk("abort_no_more", q_data.size(), 1);
    clear_q();
    step_in(1'b0, 8'h00, 1'b1, 8'hCA);
    e = cyc;
    wait_emits(1, 10, "abort_next_count");
    chk("abort_next_lat", q_cyc[0] - e, 2);
    chk("abort_next_data", q_data[0], 8'hCA);
    chk("abort_next_port", q_port[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
